axi_ram_slave: RTL and testbench

//  AXI4-subset responder backed by on-chip single-port RAM; the memory-side end of the AXI self-test master.

---
 rtl/axi_ram_slave_pkg.sv | 27 ++
 rtl/axi_ram_slave_sp.sv | 29 ++
 rtl/axi_ram_slave.sv | 166 ++++++++++++++++
 tb/tb_axi_ram_slave.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_ram_slave_pkg.sv
// Shared types for the AXI RAM responder.
// States:
//   S_INIT | one cycle after reset, no handshakes
//   S_IDLE | arbitrate between AW and AR
//   S_WR   | accept write beats
//   S_BR   | write response pending
//   S_RP   | prefetch the first read word
//   S_RD   | stream read beats
package axi_ram_slave_pkg;

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_IDLE = 3'd1,
        S_WR   = 3'd2,
        S_BR   = 3'd3,
        S_RP   = 3'd4,
        S_RD   = 3'd5
    } state_t;

    localparam int unsigned LEN_W = 8;

    // Beat size and data width have to describe the same word.
    function automatic bit width_ok(input int unsigned d_width, input int unsigned d_level);
        return d_width == (8 << d_level);
    endfunction

endpackage

// File: rtl/axi_ram_slave_sp.sv
// Single-port RAM: synchronous write, registered read with an external enable.
// The read register is reset so rdata is defined out of reset; the array is not.
module axi_ram_sp #(
    parameter int unsigned AW = 12,
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(2**AW)-1];

    // Array write port.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    // Read register, only advances when the controller asks for the next word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)   rdata <= '0;
        else if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/axi_ram_slave.sv
// AXI4-subset INCR-burst responder backed by on-chip single-port RAM.
// One burst at a time; AW/AR arbitration is round-robin when both are valid.
// Optional build macro AXI_RAM_SLAVE_PROTO_CHECK_EN adds a sticky proto_err
// flag for wlast mismatches and stray wvalid; without it proto_err is 0.
module axi_ram_slave #(
    parameter int unsigned A_WIDTH    = 26,
    parameter int unsigned D_WIDTH    = 16,
    parameter int unsigned D_LEVEL    = 1,
    parameter int unsigned MEM_AWIDTH = 12
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               awvalid,
    output logic               awready,
    input  logic [A_WIDTH-1:0] awaddr,
    input  logic [7:0]         awlen,
    input  logic               wvalid,
    output logic               wready,
    input  logic               wlast,
    input  logic [D_WIDTH-1:0] wdata,
    output logic               bvalid,
    input  logic               bready,
    input  logic               arvalid,
    output logic               arready,
    input  logic [A_WIDTH-1:0] araddr,
    input  logic [7:0]         arlen,
    output logic               rvalid,
    input  logic               rready,
    output logic               rlast,
    output logic [D_WIDTH-1:0] rdata,
    output logic               proto_err
);
    import axi_ram_slave_pkg::*;

    if (!width_ok(D_WIDTH, D_LEVEL)) begin : g_bad_width
        $error("axi_ram_slave: D_WIDTH must equal 8<<D_LEVEL");
    end
    if (MEM_AWIDTH > A_WIDTH - D_LEVEL) begin : g_bad_depth
        $error("axi_ram_slave: MEM_AWIDTH exceeds the word-address width");
    end

    state_t                 state, state_nxt;
    logic [MEM_AWIDTH-1:0]  wptr, rptr, ram_addr;
    logic [LEN_W-1:0]       len, cnt;
    logic                   last_w;
    logic                   grant_w, aw_hs, ar_hs, w_hs, r_hs, cnt_end;
    logic                   ram_we, ram_re;

    // Address bits above the RAM window alias; fold them into one unused net.
    logic unused_addr;
    assign unused_addr = ^{awaddr, araddr};

    assign cnt_end = (cnt == len);
    assign grant_w = awvalid & (~arvalid | ~last_w);
    assign aw_hs   = (state == S_IDLE) & awvalid & grant_w;
    assign ar_hs   = (state == S_IDLE) & arvalid & ~grant_w;
    assign w_hs    = (state == S_WR) & wvalid;
    assign r_hs    = (state == S_RD) & rready;

    // Last beat of a read burst does not prefetch, so its data stays on rdata.
    assign ram_we   = w_hs;
    assign ram_re   = (state == S_RP) | (r_hs & ~cnt_end);
    assign ram_addr = (state == S_WR) ? wptr : rptr;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_INIT;
        else       state <= state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        awready   = 1'b0;
        arready   = 1'b0;
        wready    = 1'b0;
        bvalid    = 1'b0;
        rvalid    = 1'b0;
        rlast     = 1'b0;
        case (state)
            S_INIT: state_nxt = S_IDLE;
            S_IDLE: begin
                awready = aw_hs;
                arready = ar_hs;
                if (aw_hs)      state_nxt = S_WR;
                else if (ar_hs) state_nxt = S_RP;
            end
            S_WR: begin
                wready = 1'b1;
                if (wvalid && cnt_end) state_nxt = S_BR;
            end
            S_BR: begin
                bvalid = 1'b1;
                if (bready) state_nxt = S_IDLE;
            end
            S_RP: state_nxt = S_RD;
            S_RD: begin
                rvalid = 1'b1;
                rlast  = cnt_end;
                if (rready && cnt_end) state_nxt = S_IDLE;
            end
            default: state_nxt = S_INIT;
        endcase
    end

    // Burst pointers, beat counter and round-robin history.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr   <= '0;
            rptr   <= '0;
            len    <= '0;
            cnt    <= '0;
            last_w <= 1'b0;
        end else begin
            if (aw_hs) begin
                wptr   <= awaddr[D_LEVEL +: MEM_AWIDTH];
                len    <= awlen;
                cnt    <= '0;
                last_w <= 1'b1;
            end else if (ar_hs) begin
                rptr   <= araddr[D_LEVEL +: MEM_AWIDTH];
                len    <= arlen;
                cnt    <= '0;
                last_w <= 1'b0;
            end
            if (w_hs) begin
                wptr <= wptr + 1'b1;
                cnt  <= cnt + 1'b1;
            end
            if (state == S_RP) rptr <= rptr + 1'b1;
            if (r_hs) begin
                rptr <= rptr + 1'b1;
                cnt  <= cnt + 1'b1;
            end
        end
    end

    axi_ram_sp #(
        .AW (MEM_AWIDTH),
        .DW (D_WIDTH)
    ) u_ram (
        .clk   (clk),
        .rstn  (rstn),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (wdata),
        .rdata (rdata)
    );

`ifdef AXI_RAM_SLAVE_PROTO_CHECK_EN
    // Sticky flag: wlast disagreeing with the beat count, or wvalid where no W is expected.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            proto_err <= 1'b0;
        else if ((w_hs && (wlast != cnt_end)) ||
                 (wvalid && (state == S_IDLE || state == S_BR)))
            proto_err <= 1'b1;
    end
`else
    logic unused_wlast;
    assign unused_wlast = wlast;
    assign proto_err    = 1'b0;
`endif

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed bench for axi_ram_slave with a word-array memory model and an
// expected read-beat queue checked every cycle rvalid is high.
module tb_axi_ram_slave;

    localparam int A_WIDTH    = 26;
    localparam int D_WIDTH    = 16;
    localparam int D_LEVEL    = 1;
    localparam int MEM_AWIDTH = 12;
    localparam int DEPTH      = 4096;
`ifdef AXI_RAM_SLAVE_PROTO_CHECK_EN
    localparam bit PROTO_EN = 1'b1;
`else
    localparam bit PROTO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b1;
    logic awvalid = 0, wvalid = 0, wlast = 0, bready = 0, arvalid = 0, rready = 0;
    logic [A_WIDTH-1:0] awaddr = '0, araddr = '0;
    logic [7:0] awlen = '0, arlen = '0;
    logic [D_WIDTH-1:0] wdata = '0;
    logic awready, wready, bvalid, arready, rvalid, rlast, proto_err;
    logic [D_WIDTH-1:0] rdata;

    always #5 clk = ~clk;

    axi_ram_slave #(
        .A_WIDTH(A_WIDTH), .D_WIDTH(D_WIDTH), .D_LEVEL(D_LEVEL), .MEM_AWIDTH(MEM_AWIDTH)
    ) dut (
        .clk(clk), .rstn(rstn),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .wvalid(wvalid), .wready(wready), .wlast(wlast), .wdata(wdata),
        .bvalid(bvalid), .bready(bready),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .rvalid(rvalid), .rready(rready), .rlast(rlast), .rdata(rdata),
        .proto_err(proto_err)
    );

    int checks = 0;
    int failures = 0;

    typedef struct { logic [15:0] d; logic l; } beat_t;
    beat_t       exp_q[$];
    logic [15:0] mem_m [0:DEPTH-1];
    logic        exp_proto = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Per-cycle read-channel and proto_err comparison against the model.
    initial forever begin
        @(negedge clk);
        #2;
        if (rstn) begin
            if (rvalid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL r_unexpected: rvalid=1 rdata=0x%0h with no beat expected", rdata);
                end else begin
                    chk("rdata", rdata, exp_q[0].d);
                    chk("rlast", rlast, exp_q[0].l);
                    if (rready) void'(exp_q.pop_front());
                end
            end else begin
                chk("rlast_idle", rlast, 0);
            end
            chk("proto_err", proto_err, exp_proto);
        end
    end

    // Call between a negedge and the following posedge.
    task automatic write_burst(input logic [25:0] addr, input int len,
                               input logic [15:0] base, input int wl_beat);
        int t;
        int w;
        w = int'((addr >> D_LEVEL) % DEPTH);
        awaddr = addr; awlen = 8'(len); awvalid = 1'b1;
        #1;
        t = 0;
        while (!awready && t < 50) begin @(negedge clk); #1; t++; end
        chk("aw_accept", awready, 1);
        chk("aw_no_ar", arready, 0);
        @(negedge clk);
        awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            wvalid = 1'b1; wdata = base + 16'(i); wlast = (i == wl_beat);
            #1;
            t = 0;
            while (!wready && t < 50) begin @(negedge clk); #1; t++; end
            if (i == 0) chk("w_latency", t, 0);
            chk("w_ready", wready, 1);
            chk("w_no_ar", arready, 0);
            chk("w_no_b", bvalid, 0);
            mem_m[w] = wdata;
            w = (w + 1) % DEPTH;
            @(negedge clk);
            if (PROTO_EN && ((i == wl_beat) != (i == len))) exp_proto = 1'b1;
        end
        wvalid = 1'b0; wlast = 1'b0;
        #1;
        chk("w_end", wready, 0);
        chk("b_valid", bvalid, 1);
        @(negedge clk); #1;
        chk("b_hold", bvalid, 1);
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        #1;
        chk("b_done", bvalid, 0);
    endtask

    // mode 0: rready always high; mode 1: rready 1,0,0 repeating.
    task automatic read_burst(input logic [25:0] addr, input int len, input int mode,
                              output logic [15:0] first_d, output logic [15:0] last_d,
                              output int nlast);
        int t, acc, cyc, w;
        beat_t b;
        w = int'((addr >> D_LEVEL) % DEPTH);
        for (int i = 0; i <= len; i++) begin
            b.d = mem_m[(w + i) % DEPTH];
            b.l = (i == len);
            exp_q.push_back(b);
        end
        araddr = addr; arlen = 8'(len); arvalid = 1'b1;
        #1;
        t = 0;
        while (!arready && t < 50) begin @(negedge clk); #1; t++; end
        chk("ar_accept", arready, 1);
        chk("ar_no_aw", awready, 0);
        @(negedge clk);
        arvalid = 1'b0;
        #1;
        chk("r_latency_rp", rvalid, 0);
        acc = 0; cyc = 0; nlast = 0; first_d = '0; last_d = '0;
        while (acc <= len && cyc < 2000) begin
            @(negedge clk);
            rready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
            #1;
            if (cyc == 0) chk("r_latency_rd", rvalid, 1);
            chk("r_no_aw", awready, 0);
            if (rvalid && rready) begin
                if (acc == 0) first_d = rdata;
                last_d = rdata;
                if (rlast) nlast++;
                acc++;
            end
            cyc++;
        end
        @(negedge clk);
        rready = 1'b0;
        #1;
        chk("r_beats", acc, len + 1);
        chk("r_done", rvalid, 0);
        chk("r_q_empty", exp_q.size(), 0);
    endtask

    logic [15:0] fd, ld;
    int nl;

    initial begin
        #1 rstn = 1'b0;
        awvalid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_arready", arready, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_proto", proto_err, 0);
        chk("rst_rdata", rdata, 0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("init_awready", awready, 0);
        @(negedge clk); #1;
        chk("idle_awready", awready, 1);
        awvalid = 1'b0;

        // 8-beat write then readback at byte 0x10.
        write_burst(26'h10, 7, 16'd8, 7);
        read_burst(26'h10, 7, 0, fd, ld, nl);
        chk("t2_first", fd, 16'd8);
        chk("t2_last", ld, 16'd15);
        chk("t2_nlast", nl, 1);

        // Stalled read, 4 beats.
        read_burst(26'h10, 3, 1, fd, ld, nl);
        chk("t3_first", fd, 16'd8);
        chk("t3_last", ld, 16'd11);
        chk("t3_nlast", nl, 1);

        // Both valid: W, then R, then W.
        araddr = 26'h100; arlen = 8'd3; arvalid = 1'b1;
        write_burst(26'h100, 3, 16'h4000, 3);
        awvalid = 1'b1; awaddr = 26'h200; awlen = 8'd1;
        read_burst(26'h100, 3, 0, fd, ld, nl);
        chk("t4_first", fd, 16'h4000);
        chk("t4_last", ld, 16'h4003);
        arvalid = 1'b1;
        write_burst(26'h200, 1, 16'h6000, 1);
        arvalid = 1'b0;

        // Wrap top->0 and upper-address aliasing.
        write_burst(26'h1FFC, 3, 16'h0500, 3);
        chk("t5_model_wrap", mem_m[0], 16'h0502);
        read_burst(26'h200_1FFC, 3, 0, fd, ld, nl);
        chk("t5_first", fd, 16'h0500);
        chk("t5_last", ld, 16'h0503);

        // Single-beat burst.
        write_burst(26'h40, 0, 16'hABCD, 0);
        read_burst(26'h40, 0, 0, fd, ld, nl);
        chk("len0_data", fd, 16'hABCD);
        chk("len0_nlast", nl, 1);

        // 256-beat burst.
        write_burst(26'h400, 255, 16'h1000, 255);
        read_burst(26'h400, 255, 0, fd, ld, nl);
        chk("len255_first", fd, 16'h1000);
        chk("len255_last", ld, 16'h10FF);
        chk("len255_nlast", nl, 1);

        // Early wlast: burst still runs to its beat count.
        chk("t6_pre_proto", proto_err, 0);
        write_burst(26'h80, 3, 16'h0700, 2);
        read_burst(26'h80, 3, 0, fd, ld, nl);
        chk("t6_last", ld, 16'h0703);
        chk("t6_proto_held", proto_err, 32'(PROTO_EN));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
